uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised, single-clock UART transmitter. It is the successor to the fixed 8-bit TX used in the UART top level. It adds:
- generic data width
- a runtime bit period (prescale) counter, so no external baud clock is needed
- selectable 1 or 2 stop bits
- a valid/ready handshake with a one-entry holding buffer, so frames go out back-to-back with no idle gap

Parameters:
DATA_WIDTH, 8, payload bits per frame (supported range 5..9).
PRESCALE_WIDTH, 8, width of the Prescale input.

Ports:
CLK  input  1  system clock.
RST  input  1  asynchronous, active-low reset.
P_DATA  input  DATA_WIDTH  parallel payload, sent LSB first.
DATA_VALID  input  1  payload offered.
DATA_READY  output  1  holding buffer empty; transfer when DATA_VALID & DATA_READY at a rising edge.
PAR_EN  input  1  1 = append parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
STOP2  input  1  1 = two stop bits, 0 = one stop bit.
Prescale  input  PRESCALE_WIDTH  bit period in CLK cycles; 0 is treated as 1.
TX_OUT  output  1  serial line; registered, idle high.
busy  output  1  high while a frame is on the line.

Behaviour:
- Reset state (asynchronous, RST low):
  - TX_OUT=1, busy=0, DATA_READY=1.
  - Holding buffer empty, FSM in IDLE, all counters 0.
- Reset mid-frame: the line returns high immediately and the frame is abandoned. The buffered word is discarded.
- Holding buffer (hold_data, hold_full):
  - DATA_READY = ~hold_full (registered-state derived).
  - On handshake, load P_DATA and set hold_full.
  - Cleared when the FSM takes the word.
  - No same-cycle bypass: if the FSM consumes on the edge where hold_full=1, READY was 0, so no simultaneous load can occur.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, busy=0.
  - If hold_full, on the next edge: go to START; load the shift register; latch PAR_EN, PAR_TYP, STOP2 and max(Prescale,1); clear hold_full.
- Configuration is latched only at START entry. Changes mid-frame do not affect the current frame.
- Latency: handshake at edge N with the FSM idle gives START at edge N+1. TX_OUT=0 and busy=1 are visible after edge N+1.
- Bit timing:
  - Bit counter counts 0..P-1, where P is the latched prescale.
  - Each line bit lasts exactly P cycles.
  - State advances when the counter = P-1.
- START: TX_OUT=0 for P cycles, then go to DATA.
- DATA:
  - Emits bits 0..DATA_WIDTH-1, LSB first; a bit index counts the data bits.
  - After the last bit, go to PARITY if the latched PAR_EN is set, else STOP.
- PARITY:
  - Even: XOR of payload. Odd: inverted XOR.
  - Lasts P cycles, then go to STOP.
- STOP:
  - TX_OUT=1 for P cycles, or 2P cycles if the latched STOP2 is set.
- End of the final stop cycle:
  - If hold_full: go directly to START; the next start bit begins on the following cycle, with zero idle cycles and busy held 1.
  - Else: go to IDLE; busy drops to 0 on that edge.
- Frame length = (1 + DATA_WIDTH + PAR_EN + 1 + STOP2) × P cycles.
- DATA_VALID may deassert without acceptance; no data is captured unless the handshake completes.
- Counter widths are sized to hold PRESCALE_WIDTH and clog2(DATA_WIDTH); there is no wrap-around within a frame.

Test Plan:
1. Reset, then send P_DATA=0xA5 with Prescale=4, PAR_EN=1, PAR_TYP=0, STOP2=0.
   - TX_OUT: 0 for 4 cycles starting 1 cycle after the handshake.
   - Data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then parity 0, then stop 1.
   - busy high for exactly 44 cycles.
2. Same frame with PAR_TYP=1 and STOP2=1.
   - Parity bit = 1; stop high for 8 cycles.
   - busy high for 48 cycles.
3. Back-to-back: offer 0x00 then 0xFF with DATA_VALID held high, PAR_EN=0, Prescale=4.
   - Second word accepted while the first is in flight; READY is 0 until the first frame starts.
   - Second start bit begins exactly 40 cycles after the first; busy never drops between frames.
4. Prescale=0 and Prescale=1, payload 0x3C.
   - Each bit lasts 1 cycle; frame is 10 cycles.
   - Output identical for both settings.
5. Change Prescale 4→8 and PAR_EN 0→1 mid-frame.
   - Current frame unaffected (40 cycles, no parity).
   - Next frame uses P=8 with parity (88 cycles).
6. Assert RST low during data bit 3 with a word buffered.
   - TX_OUT=1, busy=0, READY=1 immediately.
   - After release, no frame is emitted until a new handshake.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with runtime bit period, optional parity, 1/2 stop bits
// and a one-entry holding buffer so that frames can be sent back-to-back.
module uart_tx_cfg #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      DATA_VALID,
    output logic                      DATA_READY,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STOP2,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [DATA_WIDTH-1:0]     r_hold_data;
    logic                      r_hold_full;
    logic [DATA_WIDTH-1:0]     r_shift;
    logic                      r_par;
    logic                      r_par_en;
    logic                      r_stop2;
    logic                      r_stop_second;
    logic [PRESCALE_WIDTH-1:0] r_presc;
    logic [PRESCALE_WIDTH-1:0] r_cnt;
    logic [IDX_W-1:0]          r_bit_idx;
    logic                      r_tx;
    logic                      r_busy;

    logic                      w_accept;
    logic                      w_load;
    logic                      w_bit_end;
    logic                      w_last_bit;
    logic                      w_adv_bit;
    logic                      w_stop_second;
    logic [DATA_WIDTH-1:0]     w_shift_next;
    logic                      w_tx_next;

    assign DATA_READY = ~r_hold_full;
    assign TX_OUT     = r_tx;
    assign busy       = r_busy;
    assign w_accept   = DATA_VALID & ~r_hold_full;
    assign w_bit_end  = (r_cnt == (r_presc - 1'b1));
    assign w_last_bit = (r_bit_idx == IDX_W'(DATA_WIDTH - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_load        = 1'b0;
        w_adv_bit     = 1'b0;
        w_stop_second = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_hold_full) begin
                    w_load       = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (w_last_bit) w_state_next = r_par_en ? S_PARITY : S_STOP;
                    else            w_adv_bit    = 1'b1;
                end
            end
            S_PARITY: begin
                if (w_bit_end) w_state_next = S_STOP;
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_stop2 && !r_stop_second) begin
                        w_stop_second = 1'b1;
                    end else if (r_hold_full) begin
                        // Chain straight into the next start bit with no idle cycle
                        w_load       = 1'b1;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        if (w_load)         w_shift_next = r_hold_data;
        else if (w_adv_bit) w_shift_next = r_shift >> 1;
        else                w_shift_next = r_shift;

        // The line is registered, so it is driven from the state being entered
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
            S_PARITY: w_tx_next = r_par;
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_hold_data   <= '0;
            r_hold_full   <= 1'b0;
            r_shift       <= '0;
            r_par         <= 1'b0;
            r_par_en      <= 1'b0;
            r_stop2       <= 1'b0;
            r_stop_second <= 1'b0;
            r_presc       <= '0;
            r_cnt         <= '0;
            r_bit_idx     <= '0;
            r_tx          <= 1'b1;
            r_busy        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold_data <= P_DATA;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            r_shift <= w_shift_next;

            if (w_load) begin
                r_par         <= (^r_hold_data) ^ PAR_TYP;
                r_par_en      <= PAR_EN;
                r_stop2       <= STOP2;
                r_presc       <= (Prescale == '0) ? PRESCALE_WIDTH'(1) : Prescale;
                r_bit_idx     <= '0;
                r_stop_second <= 1'b0;
            end else begin
                if (w_adv_bit)     r_bit_idx     <= r_bit_idx + 1'b1;
                if (w_stop_second) r_stop_second <= 1'b1;
            end

            if (r_state == S_IDLE || w_bit_end || w_load) r_cnt <= '0;
            else                                          r_cnt <= r_cnt + 1'b1;

            r_tx   <= w_tx_next;
            r_busy <= (w_state_next != S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: frame shapes, parity/stop options, back-to-back
// chaining, prescale edge cases, mid-frame reconfiguration and mid-frame reset.
module tb_uart_tx_cfg;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       DATA_VALID = 1'b0;
    logic       DATA_READY;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       STOP2 = 1'b0;
    logic [7:0] Prescale = 8'd4;
    logic       TX_OUT;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_tx_cfg #(.DATA_WIDTH(8), .PRESCALE_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .DATA_READY (DATA_READY),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offers a word and returns 1 time unit after the accepting edge.
    task automatic send(input logic [7:0] d, input bit hold_valid);
        int n;
        P_DATA     = d;
        DATA_VALID = 1'b1;
        n = 0;
        while (!DATA_READY && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        check("send_ready", {31'd0, DATA_READY}, 32'd1);
        @(posedge CLK); #1;
        if (!hold_valid) DATA_VALID = 1'b0;
    endtask

    // Frame bits are given in line order (bits[0] = start bit); called one unit after
    // the edge preceding the first frame cycle to check (cycle index skip).
    task automatic check_frame(input string tag, input logic [15:0] bits, input int nbits,
                               input int p, input int skip);
        for (int k = skip; k < nbits * p; k++) begin
            @(posedge CLK); #1;
            check($sformatf("%s_tx%0d", tag, k), {31'd0, TX_OUT}, {31'd0, bits[k / p]});
            check($sformatf("%s_busy%0d", tag, k), {31'd0, busy}, 32'd1);
        end
    endtask

    task automatic check_idle_after(input string tag);
        @(posedge CLK); #1;
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        check({tag, "_tx_end"}, {31'd0, TX_OUT}, 32'd1);
    endtask

    initial begin
        int n;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_tx", {31'd0, TX_OUT}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, DATA_READY}, 32'd1);
        RST = 1'b1;
        @(posedge CLK); #1;
        check("post_rst_tx", {31'd0, TX_OUT}, 32'd1);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // 1: 0xA5, P=4, even parity, one stop -> 44 cycles
        Prescale = 8'd4; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0;
        send(8'hA5, 1'b0);
        check("t1_ready_full", {31'd0, DATA_READY}, 32'd0);
        check_frame("t1", {5'd0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 4, 0);
        check_idle_after("t1");

        // 2: odd parity and two stop bits -> 48 cycles
        PAR_TYP = 1'b1; STOP2 = 1'b1;
        send(8'hA5, 1'b0);
        check_frame("t2", {4'd0, 2'b11, 1'b1, 8'hA5, 1'b0}, 12, 4, 0);
        check_idle_after("t2");
        PAR_TYP = 1'b0; STOP2 = 1'b0;

        // 3: back-to-back 0x00 then 0xFF with VALID held high
        PAR_EN = 1'b0; Prescale = 8'd4;
        send(8'h00, 1'b1);
        fork
            begin
                check_frame("t3a", {6'd0, 1'b1, 8'h00, 1'b0}, 10, 4, 0);
                check_frame("t3b", {6'd0, 1'b1, 8'hFF, 1'b0}, 10, 4, 0);
            end
            begin
                P_DATA = 8'hFF;
                check("t3_ready_low", {31'd0, DATA_READY}, 32'd0);
                n = 0;
                while (!DATA_READY && n < 50) begin
                    @(posedge CLK); #1;
                    n++;
                end
                check("t3_ready_wait", n, 32'd1);
                @(posedge CLK); #1;
                DATA_VALID = 1'b0;
                check("t3_ready_refull", {31'd0, DATA_READY}, 32'd0);
            end
        join
        check_idle_after("t3");

        // 4: Prescale 0 and 1 give identical one-cycle bits
        Prescale = 8'd0;
        send(8'h3C, 1'b0);
        check_frame("t4p0", {6'd0, 1'b1, 8'h3C, 1'b0}, 10, 1, 0);
        check_idle_after("t4p0");
        Prescale = 8'd1;
        send(8'h3C, 1'b0);
        check_frame("t4p1", {6'd0, 1'b1, 8'h3C, 1'b0}, 10, 1, 0);
        check_idle_after("t4p1");

        // 5: reconfigure mid-frame; only the next frame sees P=8 with parity
        Prescale = 8'd4; PAR_EN = 1'b0;
        send(8'h5A, 1'b0);
        fork
            begin
                check_frame("t5a", {6'd0, 1'b1, 8'h5A, 1'b0}, 10, 4, 0);
                check_frame("t5b", {5'd0, 1'b1, 1'b0, 8'h81, 1'b0}, 11, 8, 0);
            end
            begin
                send(8'h81, 1'b0);
                repeat (10) @(posedge CLK);
                #1;
                Prescale = 8'd8; PAR_EN = 1'b1;
            end
        join
        check_idle_after("t5");

        // 6: reset during data bit 3 with a word buffered
        Prescale = 8'd4; PAR_EN = 1'b0;
        send(8'hA5, 1'b0);
        send(8'h33, 1'b0);
        check("t6_buffered", {31'd0, DATA_READY}, 32'd0);
        repeat (15) @(posedge CLK);
        #1;
        check("t6_bit3", {31'd0, TX_OUT}, 32'd0);
        #2;
        RST = 1'b0;
        #1;
        check("t6_rst_tx", {31'd0, TX_OUT}, 32'd1);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_ready", {31'd0, DATA_READY}, 32'd1);
        @(posedge CLK); #1;
        RST = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge CLK); #1;
            check($sformatf("t6_quiet_tx%0d", i), {31'd0, TX_OUT}, 32'd1);
            check($sformatf("t6_quiet_busy%0d", i), {31'd0, busy}, 32'd0);
        end
        check("t6_ready_after", {31'd0, DATA_READY}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
